// File: rtl/timing_check_monitor.sv
// -----------------------------------------------------------------------------
// timing_check_monitor
//
// Purpose:
//    Run-time, synthesizable counterpart of specify-block $setup, $hold and
//    $skew checks. A data bus and two reference strobes are oversampled on a
//    fast clk. The block measures the setup margin, the hold margin and the
//    strobe-to-strobe skew in clk cycles. It flags violations with one-cycle
//    pulses and keeps saturating violation counts.
//
// Ports:
//    clk         in   1      sampling clock, rising edge
//    rst         in   1      asynchronous, active-high reset
//    en          in   1      check enable
//    clr_cnt     in   1      synchronous clear of all violation counters
//    data_i      in   DW     monitored data, asynchronous to clk
//    ref_i       in   1      reference strobe, checked on its rising edge
//    ref2_i      in   1      second strobe for the skew check
//    setup_viol  out  1      one-cycle pulse on a setup violation
//    hold_viol   out  1      one-cycle pulse on a hold violation
//    skew_viol   out  1      one-cycle pulse on a skew violation
//    last_margin out  TW     setup margin measured at the latest ref rise
//    setup_cnt   out  CNT_W  saturating setup violation count
//    hold_cnt    out  CNT_W  saturating hold violation count
//    skew_cnt    out  CNT_W  saturating skew violation count
// -----------------------------------------------------------------------------
module timing_check_monitor #(
   parameter int DW        = 8,
   parameter int SETUP_CYC = 4,
   parameter int HOLD_CYC  = 3,
   parameter int SKEW_CYC  = 2,
   parameter int TW        = 8,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr_cnt,
   input  logic [DW-1:0]    data_i,
   input  logic             ref_i,
   input  logic             ref2_i,
   output logic             setup_viol,
   output logic             hold_viol,
   output logic             skew_viol,
   output logic [TW-1:0]    last_margin,
   output logic [CNT_W-1:0] setup_cnt,
   output logic [CNT_W-1:0] hold_cnt,
   output logic [CNT_W-1:0] skew_cnt
);

   localparam int HTW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC + 1) : 1;
   localparam int STW = $clog2(SKEW_CYC + 2);

   localparam logic [TW-1:0]    SINCE_MAX = {TW{1'b1}};
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [TW-1:0]    SETUP_LIM = TW'(SETUP_CYC);
   localparam logic [HTW-1:0]   HOLD_LOAD = HTW'(HOLD_CYC);
   localparam logic [STW-1:0]   SKEW_LIM  = STW'(SKEW_CYC);
   localparam bit               HOLD_ON   = (HOLD_CYC > 0);

   typedef enum logic {
      IDLE,
      HOLD_WIN
   } hold_state_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_A,
      S_B
   } skew_state_t;

   // Synchroniser, previous-value stage and registered events
   logic [DW-1:0] data_s1, data_s2, data_p;
   logic          ref_s1, ref_s2, ref_p;
   logic          ref2_s1, ref2_s2, ref2_p;
   logic [1:0]    prime_cnt;
   logic          primed;
   logic          data_ev, ref_ev, ref2_ev;

   // Setup measurement
   logic [TW-1:0] since_q;
   logic [TW-1:0] since_cur;
   logic          setup_hit;

   // Hold FSM
   hold_state_t    hold_state, hold_state_n;
   logic [HTW-1:0] hold_tmr, hold_tmr_n;
   logic           hold_hit;

   // Skew FSM
   skew_state_t    skew_state, skew_state_n;
   logic [STW-1:0] skew_tmr, skew_tmr_n;
   logic           skew_hit;

   // The pipeline flops come out of reset at 0 while the pins may already be
   // high or non-zero. Events stay masked until the previous stage holds a
   // real sample, so no edge is invented from reset values.
   assign primed = (prime_cnt == 2'd3);

   // Every path has the same depth (two sync flops, one previous stage, one
   // event register), so relative timing between data and strobes is kept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_s1   <= '0;
         data_s2   <= '0;
         data_p    <= '0;
         ref_s1    <= 1'b0;
         ref_s2    <= 1'b0;
         ref_p     <= 1'b0;
         ref2_s1   <= 1'b0;
         ref2_s2   <= 1'b0;
         ref2_p    <= 1'b0;
         prime_cnt <= 2'd0;
         data_ev   <= 1'b0;
         ref_ev    <= 1'b0;
         ref2_ev   <= 1'b0;
      end else begin
         data_s1   <= data_i;
         data_s2   <= data_s1;
         data_p    <= data_s2;
         ref_s1    <= ref_i;
         ref_s2    <= ref_s1;
         ref_p     <= ref_s2;
         ref2_s1   <= ref2_i;
         ref2_s2   <= ref2_s1;
         ref2_p    <= ref2_s2;
         prime_cnt <= primed ? prime_cnt : prime_cnt + 2'd1;
         data_ev   <= primed && (data_s2 != data_p);
         ref_ev    <= primed && ref_s2 && !ref_p;
         ref2_ev   <= primed && ref2_s2 && !ref2_p;
      end
   end

   // since_cur is the age of the data in the current cycle: zero in the
   // cycle of a data event, so a same-cycle ref rise sees a margin of 0.
   assign since_cur = data_ev ? '0 : since_q;
   assign setup_hit = en && ref_ev && (since_cur < SETUP_LIM);

   // The age keeps counting even with en low so margins stay valid when
   // checking resumes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         since_q <= '0;
      end else begin
         since_q <= (since_cur == SINCE_MAX) ? SINCE_MAX : since_cur + TW'(1);
      end
   end

   // Hold window. A ref rise inside an open window reloads it; a data event
   // in that same cycle belongs to the new ref and is scored as setup.
   always_comb begin
      hold_state_n = hold_state;
      hold_tmr_n   = hold_tmr;
      hold_hit     = 1'b0;
      if (!en) begin
         hold_state_n = IDLE;
         hold_tmr_n   = '0;
      end else begin
         case (hold_state)
            IDLE: begin
               if (ref_ev && HOLD_ON) begin
                  hold_state_n = HOLD_WIN;
                  hold_tmr_n   = HOLD_LOAD;
               end
            end
            HOLD_WIN: begin
               if (ref_ev) begin
                  hold_tmr_n = HOLD_LOAD;
               end else if (data_ev) begin
                  hold_hit     = 1'b1;
                  hold_state_n = IDLE;
                  hold_tmr_n   = '0;
               end else if (hold_tmr <= HTW'(1)) begin
                  hold_state_n = IDLE;
                  hold_tmr_n   = '0;
               end else begin
                  hold_tmr_n = hold_tmr - HTW'(1);
               end
            end
            default: begin
               hold_state_n = IDLE;
               hold_tmr_n   = '0;
            end
         endcase
      end
   end

   // Skew pairing. S_A waits for ref2 after ref, S_B waits for ref after
   // ref2. A partner arriving in the same cycle as the timeout is late and
   // closes the pair with a single violation.
   always_comb begin
      skew_state_n = skew_state;
      skew_tmr_n   = skew_tmr;
      skew_hit     = 1'b0;
      if (!en) begin
         skew_state_n = S_IDLE;
         skew_tmr_n   = '0;
      end else begin
         case (skew_state)
            S_IDLE: begin
               if (ref_ev && !ref2_ev) begin
                  skew_state_n = S_A;
                  skew_tmr_n   = STW'(1);
               end else if (ref2_ev && !ref_ev) begin
                  skew_state_n = S_B;
                  skew_tmr_n   = STW'(1);
               end
            end
            S_A: begin
               if (ref2_ev) begin
                  skew_hit     = (skew_tmr > SKEW_LIM);
                  skew_state_n = S_IDLE;
                  skew_tmr_n   = '0;
               end else if (ref_ev) begin
                  skew_hit   = 1'b1;
                  skew_tmr_n = STW'(1);
               end else if (skew_tmr > SKEW_LIM) begin
                  skew_hit     = 1'b1;
                  skew_state_n = S_IDLE;
                  skew_tmr_n   = '0;
               end else begin
                  skew_tmr_n = skew_tmr + STW'(1);
               end
            end
            S_B: begin
               if (ref_ev) begin
                  skew_hit     = (skew_tmr > SKEW_LIM);
                  skew_state_n = S_IDLE;
                  skew_tmr_n   = '0;
               end else if (ref2_ev) begin
                  skew_hit   = 1'b1;
                  skew_tmr_n = STW'(1);
               end else if (skew_tmr > SKEW_LIM) begin
                  skew_hit     = 1'b1;
                  skew_state_n = S_IDLE;
                  skew_tmr_n   = '0;
               end else begin
                  skew_tmr_n = skew_tmr + STW'(1);
               end
            end
            default: begin
               skew_state_n = S_IDLE;
               skew_tmr_n   = '0;
            end
         endcase
      end
   end

   // FSM state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_state <= IDLE;
         hold_tmr   <= '0;
         skew_state <= S_IDLE;
         skew_tmr   <= '0;
      end else begin
         hold_state <= hold_state_n;
         hold_tmr   <= hold_tmr_n;
         skew_state <= skew_state_n;
         skew_tmr   <= skew_tmr_n;
      end
   end

   // Counters step on the same edge that raises the pulse, so a clear in
   // that cycle leaves the matching counter at 1.
   function automatic logic [CNT_W-1:0] next_count(
      input logic [CNT_W-1:0] cur,
      input logic             clr,
      input logic             hit
   );
      if (clr) begin
         next_count = hit ? CNT_W'(1) : '0;
      end else if (hit && (cur != CNT_MAX)) begin
         next_count = cur + CNT_W'(1);
      end else begin
         next_count = cur;
      end
   endfunction

   // Registered pulses, margin capture and counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         setup_viol  <= 1'b0;
         hold_viol   <= 1'b0;
         skew_viol   <= 1'b0;
         last_margin <= '0;
         setup_cnt   <= '0;
         hold_cnt    <= '0;
         skew_cnt    <= '0;
      end else begin
         setup_viol <= setup_hit;
         hold_viol  <= hold_hit;
         skew_viol  <= skew_hit;
         if (en && ref_ev) begin
            last_margin <= since_cur;
         end
         setup_cnt <= next_count(setup_cnt, clr_cnt, setup_hit);
         hold_cnt  <= next_count(hold_cnt, clr_cnt, hold_hit);
         skew_cnt  <= next_count(skew_cnt, clr_cnt, skew_hit);
      end
   end

endmodule
